seg_display_arbiter: RTL and testbench

- Owns the 4-digit active-low seven-segment display for the rhythm game and shares it between three sources.
- Sources, by priority: transient message (HIT/MISS etc.) > note-lane pattern > BCD score.
- Performs digit scan multiplexing.
- Switches source only at frame boundaries, so a frame is never torn.
- Sits between game logic and the anode/segs board pins.

---
 rtl/seg_display_arbiter.sv | 148 ++++++++++++++
 tb/tb_seg_display_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_display_arbiter.sv
// Four-digit active-low seven-segment driver shared between score, note lane and
// transient message sources; scans digits and changes source only between frames.
module seg_display_arbiter #(
    parameter int SCAN_DIV = 100000,
    parameter int MSG_HOLD = 250,
    parameter int HOLD_W   = 16
) (
    input  logic        clk_in,
    input  logic        RESET,
    input  logic [15:0] score_bcd,
    input  logic        note_valid,
    input  logic [27:0] note_segs,
    input  logic        msg_req,
    input  logic [27:0] msg_segs,
    output logic        msg_ack,
    output logic [3:0]  anode,
    output logic [6:0]  segs,
    output logic [1:0]  src
);

    localparam int                CNT_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_FULL = HOLD_W'(MSG_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_BND  = HOLD_W'(MSG_HOLD - 1);
    localparam logic [6:0]        SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        SRC_SCORE = 2'd0,
        SRC_NOTE  = 2'd1,
        SRC_MSG   = 2'd2
    } src_e;

    // Handshake: msg_req is sampled every cycle and the arbiter is always ready, so
    // each cycle with msg_req=1 is one accepted request, answered by a one-cycle
    // msg_ack pulse in the following cycle. There is no backpressure.

    logic [CNT_W-1:0]  scan_cnt, scan_cnt_nxt;
    logic [1:0]        digit, digit_nxt;
    src_e              src_q, src_nxt;
    logic              msg_active, msg_active_nxt;
    logic [HOLD_W-1:0] hold, hold_nxt;
    logic [27:0]       msg_pat, msg_pat_nxt;
    logic [3:0]        anode_nxt;
    logic [6:0]        segs_nxt;
    logic [6:0]        score_seg;
    logic              at_tc;
    logic              at_boundary;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
        case (v)
            4'd0:    bcd_to_seg = 7'h40;
            4'd1:    bcd_to_seg = 7'h79;
            4'd2:    bcd_to_seg = 7'h24;
            4'd3:    bcd_to_seg = 7'h30;
            4'd4:    bcd_to_seg = 7'h19;
            4'd5:    bcd_to_seg = 7'h12;
            4'd6:    bcd_to_seg = 7'h02;
            4'd7:    bcd_to_seg = 7'h78;
            4'd8:    bcd_to_seg = 7'h00;
            4'd9:    bcd_to_seg = 7'h10;
            default: bcd_to_seg = SEG_BLANK;
        endcase
    endfunction

    function automatic logic [6:0] lane_sel(input logic [27:0] v, input logic [1:0] d);
        case (d)
            2'd0:    lane_sel = v[6:0];
            2'd1:    lane_sel = v[13:7];
            2'd2:    lane_sel = v[20:14];
            default: lane_sel = v[27:21];
        endcase
    endfunction

    always_comb begin
        at_tc          = (scan_cnt == CNT_LAST);
        at_boundary    = at_tc && (digit == 2'd3);
        scan_cnt_nxt   = at_tc ? '0 : scan_cnt + 1'b1;
        digit_nxt      = at_tc ? digit + 2'd1 : digit;
        src_nxt        = src_q;
        msg_active_nxt = msg_active;
        hold_nxt       = hold;
        msg_pat_nxt    = msg_pat;

        // A message whose hold has run out is dropped and the boundary falls
        // through to the note/score choice in the same cycle.
        if (at_boundary) begin
            if (msg_req) begin
                src_nxt = SRC_MSG;
            end else if (msg_active && (hold != '0)) begin
                src_nxt  = SRC_MSG;
                hold_nxt = hold - 1'b1;
            end else begin
                msg_active_nxt = 1'b0;
                src_nxt        = note_valid ? SRC_NOTE : SRC_SCORE;
            end
        end

        // The boundary accept already counts its first frame, hence one less.
        if (msg_req) begin
            msg_pat_nxt    = msg_segs;
            msg_active_nxt = 1'b1;
            hold_nxt       = at_boundary ? HOLD_BND : HOLD_FULL;
        end

        // Higher digits blank while they and everything above them are zero.
        case (digit)
            2'd0:    score_seg = bcd_to_seg(score_bcd[3:0]);
            2'd1:    score_seg = (score_bcd[15:4] == 12'd0) ? SEG_BLANK : bcd_to_seg(score_bcd[7:4]);
            2'd2:    score_seg = (score_bcd[15:8] == 8'd0) ? SEG_BLANK : bcd_to_seg(score_bcd[11:8]);
            default: score_seg = (score_bcd[15:12] == 4'd0) ? SEG_BLANK : bcd_to_seg(score_bcd[15:12]);
        endcase

        case (src_q)
            SRC_MSG:  segs_nxt = lane_sel(msg_pat, digit);
            SRC_NOTE: segs_nxt = lane_sel(note_segs, digit);
            default:  segs_nxt = score_seg;
        endcase

        anode_nxt = ~(4'b0001 << digit);
    end

    always_ff @(posedge clk_in) begin
        if (!RESET) begin
            scan_cnt   <= '0;
            digit      <= 2'd0;
            src_q      <= SRC_SCORE;
            msg_active <= 1'b0;
            hold       <= '0;
            msg_pat    <= '0;
            msg_ack    <= 1'b0;
            anode      <= 4'b1111;
            segs       <= SEG_BLANK;
        end else begin
            scan_cnt   <= scan_cnt_nxt;
            digit      <= digit_nxt;
            src_q      <= src_nxt;
            msg_active <= msg_active_nxt;
            hold       <= hold_nxt;
            msg_pat    <= msg_pat_nxt;
            msg_ack    <= msg_req;
            anode      <= anode_nxt;
            segs       <= segs_nxt;
        end
    end

    assign src = src_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed-then-random bench for seg_display_arbiter; expectations come from a
// timeline model (cycle index arithmetic, last-accept time) kept in the bench.
module tb_seg_display_arbiter;

    localparam int SCAN_DIV = 4;
    localparam int MSG_HOLD = 2;
    localparam int HOLD_W   = 16;
    localparam int FRAME    = 4 * SCAN_DIV;

    logic        clk_in = 1'b0;
    logic        RESET;
    logic [15:0] score_bcd;
    logic        note_valid;
    logic [27:0] note_segs;
    logic        msg_req;
    logic [27:0] msg_segs;
    logic        msg_ack;
    logic [3:0]  anode;
    logic [6:0]  segs;
    logic [1:0]  src;

    always #5 clk_in = ~clk_in;

    seg_display_arbiter #(
        .SCAN_DIV(SCAN_DIV),
        .MSG_HOLD(MSG_HOLD),
        .HOLD_W  (HOLD_W)
    ) dut (
        .clk_in    (clk_in),
        .RESET     (RESET),
        .score_bcd (score_bcd),
        .note_valid(note_valid),
        .note_segs (note_segs),
        .msg_req   (msg_req),
        .msg_segs  (msg_segs),
        .msg_ack   (msg_ack),
        .anode     (anode),
        .segs      (segs),
        .src       (src)
    );

    int total = 0;
    int bad   = 0;

    // Model: t counts clock edges since reset release; last_acc is the cycle of
    // the most recent accepted message; m_src is the source of the upcoming cycle.
    int          t        = 0;
    int          last_acc = -1;
    logic [1:0]  m_src    = 2'd0;
    logic [27:0] m_pat    = '0;
    logic [13:0] exp_q[$];

    function automatic logic [6:0] bcd7(input logic [3:0] v);
        logic [6:0] tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        return (v < 4'd10) ? tbl[v] : 7'h7F;
    endfunction

    function automatic logic [6:0] score_digit(input logic [15:0] s, input int d);
        logic [15:0] above;
        above = s >> (4 * d);
        if (d > 0 && above == 16'd0) return 7'h7F;
        return bcd7(s[4*d +: 4]);
    endfunction

    function automatic logic [6:0] lane(input logic [27:0] v, input int d);
        return v[7*d +: 7];
    endfunction

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
        end
    endtask

    // One clock: predict from the inputs now on the pins, clock, then compare.
    task automatic step();
        logic [13:0] e;
        logic [6:0]  es;
        int          d;
        int          nbnd;
        if (!RESET) begin
            e        = {1'b0, 2'd0, 4'b1111, 7'h7F};
            t        = 0;
            last_acc = -1;
            m_src    = 2'd0;
        end else begin
            d = (t / SCAN_DIV) % 4;
            case (m_src)
                2'd2:    es = lane(m_pat, d);
                2'd1:    es = lane(note_segs, d);
                default: es = score_digit(score_bcd, d);
            endcase
            if (msg_req) begin
                last_acc = t;
                m_pat    = msg_segs;
            end
            if (t % FRAME == FRAME - 1) begin
                // frames started since the accept, counting the one about to start
                nbnd = (last_acc >= 0) ? ((t + 1) / FRAME - last_acc / FRAME) : MSG_HOLD + 1;
                if (nbnd <= MSG_HOLD) m_src = 2'd2;
                else                  m_src = note_valid ? 2'd1 : 2'd0;
            end
            e = {msg_req, m_src, ~(4'b0001 << d), es};
            t++;
        end
        exp_q.push_back(e);
        @(posedge clk_in);
        #1;
        e = exp_q.pop_front();
        chk("msg_ack", {6'd0, msg_ack}, {6'd0, e[13]});
        chk("src",     {5'd0, src},     {5'd0, e[12:11]});
        chk("anode",   {3'd0, anode},   {3'd0, e[10:7]});
        chk("segs",    segs,            e[6:0]);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic go_to(input int phase);
        for (int i = 0; i < FRAME && (t % FRAME) != phase; i++) step();
    endtask

    task automatic pulse_msg(input logic [27:0] pat);
        msg_req  = 1'b1;
        msg_segs = pat;
        step();
        msg_req  = 1'b0;
        msg_segs = 28'($urandom);
    endtask

    logic [15:0] score_tbl [6] = '{16'h0042, 16'h0000, 16'h0905, 16'h1000, 16'h00A7, 16'h9876};

    initial begin
        RESET      = 1'b0;
        score_bcd  = '0;
        note_valid = 1'b0;
        note_segs  = '0;
        msg_req    = 1'b0;
        msg_segs   = '0;

        // reset held with arbitrary inputs
        for (int i = 0; i < 3; i++) begin
            score_bcd  = 16'($urandom);
            note_valid = 1'($urandom);
            note_segs  = 28'($urandom);
            msg_req    = 1'($urandom);
            msg_segs   = 28'($urandom);
            step();
        end
        RESET      = 1'b1;
        note_valid = 1'b0;
        msg_req    = 1'b0;

        // score only, several values including blanking corners
        foreach (score_tbl[i]) begin
            score_bcd = score_tbl[i];
            run(FRAME);
        end
        score_bcd = 16'h0042;

        // note raised mid-frame takes over at the next boundary
        go_to(6);
        note_valid = 1'b1;
        note_segs  = 28'h0000000;
        run(2 * FRAME);

        // single message pulse, then revert to note
        go_to(5);
        pulse_msg(28'h0FFFFFF);
        run(4 * FRAME);

        // note dropped mid-frame finishes its frame, then score
        go_to(9);
        note_valid = 1'b0;
        run(2 * FRAME);

        // retrigger during the second frame of a message
        go_to(3);
        pulse_msg(28'($urandom));
        go_to(0);
        run(FRAME + 7);
        pulse_msg(28'($urandom));
        run(4 * FRAME);

        // accept landing exactly on a boundary cycle
        go_to(FRAME - 1);
        pulse_msg(28'($urandom));
        run(4 * FRAME);

        // continuously held request
        note_valid = 1'b1;
        msg_req    = 1'b1;
        for (int i = 0; i < 40; i++) begin
            msg_segs = 28'($urandom);
            step();
        end
        msg_req = 1'b0;
        run(4 * FRAME);

        // reset mid-message discards it
        go_to(2);
        pulse_msg(28'h1234567);
        run(FRAME);
        RESET = 1'b0;
        run(2);
        RESET      = 1'b1;
        note_valid = 1'b0;
        run(4 * FRAME);

        // random traffic
        for (int i = 0; i < 800; i++) begin
            score_bcd = 16'($urandom);
            note_segs = 28'($urandom);
            msg_segs  = 28'($urandom);
            if ($urandom_range(0, 19) == 0) note_valid = ~note_valid;
            msg_req = ($urandom_range(0, 39) == 0);
            RESET   = ($urandom_range(0, 199) != 0);
            step();
        end
        RESET   = 1'b1;
        msg_req = 1'b0;
        run(FRAME);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
